cam_cmd_scheduler: RTL and testbench

- Front-end stage directly upstream of the 32-entry x 32-bit CAM.
- Accepts read/write/search commands over a valid/ready stream and buffers them.
- Issues at most one CAM operation per cycle and captures the CAM results.
- Returns exactly one in-order response per command over a valid/ready stream, with backpressure handled by credits.

---
 rtl/cam_pkg.sv | 29 ++
 rtl/cam_sync_fifo.sv | 67 ++++++
 rtl/cam_cmd_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_cam_cmd_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared CAM geometry constants and command/response payload types used by the
// command scheduler and its FIFOs.
package cam_pkg;

  localparam int unsigned CAM_ENTRIES = 32;
  localparam int unsigned CAM_IDX_W   = $clog2(CAM_ENTRIES);
  localparam int unsigned CAM_DATA_W  = 32;

  typedef enum logic [1:0] {
    READ    = 2'd0,
    WRITE   = 2'd1,
    SEARCH  = 2'd2,
    ILLEGAL = 2'd3
  } cam_op_e;

  typedef struct packed {
    cam_op_e               op;
    logic [CAM_IDX_W-1:0]  index;
    logic [CAM_DATA_W-1:0] data;
  } cam_cmd_t;

  typedef struct packed {
    cam_op_e               op;
    logic                  hit;
    logic [CAM_IDX_W-1:0]  index;
    logic [CAM_DATA_W-1:0] data;
  } cam_rsp_t;

endpackage

// File: rtl/cam_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count; DEPTH must be
// a power of two. Pushes while full are dropped (callers guarantee they never happen).
module cam_sync_fifo #(
  parameter type         T     = logic [7:0],
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  T                      push_data_i,
  input  logic                  pop_i,
  output T                      head_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  T                 mem_q [DEPTH];
  T                 mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is pure datapath; validity is tracked by the pointers alone.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cam_cmd_scheduler.sv
// Buffers CAM commands, issues one registered CAM operation per cycle under a
// response-credit limit, and returns one in-order response per command.
module cam_cmd_scheduler
  import cam_pkg::*;
#(
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned RSP_DEPTH = 4,
  parameter int unsigned CAM_LAT   = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [CAM_IDX_W-1:0]  cmd_index_i,
  input  logic [CAM_DATA_W-1:0] cmd_data_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [1:0]            rsp_op_o,
  output logic                  rsp_hit_o,
  output logic [CAM_IDX_W-1:0]  rsp_index_o,
  output logic [CAM_DATA_W-1:0] rsp_data_o,
  output logic                  cam_read_enable_o,
  output logic [CAM_IDX_W-1:0]  cam_read_index_o,
  output logic                  cam_write_enable_o,
  output logic [CAM_IDX_W-1:0]  cam_write_index_o,
  output logic [CAM_DATA_W-1:0] cam_write_data_o,
  output logic                  cam_search_enable_o,
  output logic [CAM_DATA_W-1:0] cam_search_data_o,
  input  logic                  cam_read_valid_i,
  input  logic [CAM_DATA_W-1:0] cam_read_value_i,
  input  logic                  cam_search_valid_i,
  input  logic [CAM_IDX_W-1:0]  cam_search_index_i
);

  localparam int unsigned CMD_CNT_W = $clog2(CMD_DEPTH) + 1;
  localparam int unsigned RSP_CNT_W = $clog2(RSP_DEPTH) + 1;
  localparam int unsigned CRD_W     = RSP_CNT_W + 3;
  localparam int unsigned STAGES    = CAM_LAT + 1;

  cam_cmd_t              cmd_in, cmd_head;
  logic                  cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic [CMD_CNT_W-1:0]  cmd_count;
  cam_rsp_t              rsp_in, rsp_head;
  logic                  rsp_push, rsp_pop, rsp_full, rsp_empty;
  logic [RSP_CNT_W-1:0]  rsp_count;

  logic                  pipe_vld_q [STAGES];
  logic                  pipe_vld_d [STAGES];
  cam_cmd_t              pipe_cmd_q [STAGES];
  cam_cmd_t              pipe_cmd_d [STAGES];
  cam_cmd_t              tail;
  logic [CRD_W-1:0]      inflight;
  logic                  issue;

  logic                  rd_en_q, rd_en_d, wr_en_q, wr_en_d, srch_en_q, srch_en_d;
  logic [CAM_IDX_W-1:0]  rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
  logic [CAM_DATA_W-1:0] wr_data_q, wr_data_d, srch_data_q, srch_data_d;

  assign cmd_ready_o = !rst_i && (cmd_count < CMD_CNT_W'(CMD_DEPTH));
  assign cmd_push    = cmd_valid_i && cmd_ready_o;
  assign cmd_in      = '{op: cam_op_e'(cmd_op_i), index: cmd_index_i, data: cmd_data_i};
  assign cmd_pop     = issue;
  assign rsp_valid_o = !rsp_empty;
  assign rsp_pop     = rsp_valid_o && rsp_ready_i;

  cam_sync_fifo #(.T(cam_cmd_t), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (cmd_push),
    .push_data_i (cmd_in),
    .pop_i       (cmd_pop),
    .head_o      (cmd_head),
    .full_o      (cmd_full),
    .empty_o     (cmd_empty),
    .count_o     (cmd_count)
  );

  cam_sync_fifo #(.T(cam_rsp_t), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (rsp_push),
    .push_data_i (rsp_in),
    .pop_i       (rsp_pop),
    .head_o      (rsp_head),
    .full_o      (rsp_full),
    .empty_o     (rsp_empty),
    .count_o     (rsp_count)
  );

  // Issue only when every op already in flight plus this one has a response slot.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      inflight = inflight + CRD_W'(pipe_vld_q[i]);
    end
    issue = !cmd_empty && ((CRD_W'(rsp_count) + inflight) < CRD_W'(RSP_DEPTH));
  end

  always_comb begin
    rd_en_d     = 1'b0;
    wr_en_d     = 1'b0;
    srch_en_d   = 1'b0;
    rd_idx_d    = rd_idx_q;
    wr_idx_d    = wr_idx_q;
    wr_data_d   = wr_data_q;
    srch_data_d = srch_data_q;
    pipe_vld_d[0] = issue;
    pipe_cmd_d[0] = cmd_head;
    for (int unsigned i = 1; i < STAGES; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_cmd_d[i] = pipe_cmd_q[i-1];
    end
    if (issue) begin
      case (cmd_head.op)
        READ: begin
          rd_en_d  = 1'b1;
          rd_idx_d = cmd_head.index;
        end
        WRITE: begin
          wr_en_d   = 1'b1;
          wr_idx_d  = cmd_head.index;
          wr_data_d = cmd_head.data;
        end
        SEARCH: begin
          srch_en_d   = 1'b1;
          srch_data_d = cmd_head.data;
        end
        ILLEGAL: ;
      endcase
    end
  end

  // The oldest pipe stage lines up with the cycle the CAM result is valid.
  always_comb begin
    tail     = pipe_cmd_q[CAM_LAT];
    rsp_push = pipe_vld_q[CAM_LAT];
    rsp_in   = '{op: tail.op, hit: 1'b0, index: tail.index, data: tail.data};
    case (tail.op)
      READ: begin
        rsp_in.hit  = cam_read_valid_i;
        rsp_in.data = cam_read_value_i;
      end
      WRITE: rsp_in.hit = 1'b1;
      SEARCH: begin
        rsp_in.hit   = cam_search_valid_i;
        rsp_in.index = cam_search_valid_i ? cam_search_index_i : '0;
      end
      ILLEGAL: ;
    endcase
  end

  always_comb begin
    rsp_op_o    = '0;
    rsp_hit_o   = 1'b0;
    rsp_index_o = '0;
    rsp_data_o  = '0;
    if (rsp_valid_o) begin
      rsp_op_o    = rsp_head.op;
      rsp_hit_o   = rsp_head.hit;
      rsp_index_o = rsp_head.index;
      rsp_data_o  = rsp_head.data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      srch_en_q   <= 1'b0;
      rd_idx_q    <= '0;
      wr_idx_q    <= '0;
      wr_data_q   <= '0;
      srch_data_q <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_cmd_q[i] <= '0;
      end
    end else begin
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      srch_en_q   <= srch_en_d;
      rd_idx_q    <= rd_idx_d;
      wr_idx_q    <= wr_idx_d;
      wr_data_q   <= wr_data_d;
      srch_data_q <= srch_data_d;
      for (int unsigned i = 0; i < STAGES; i++) begin
        pipe_vld_q[i] <= pipe_vld_d[i];
        pipe_cmd_q[i] <= pipe_cmd_d[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(rsp_push && rsp_full));
      assert (!(cmd_push && cmd_full));
    end
  end

  assign cam_read_enable_o   = rd_en_q;
  assign cam_read_index_o    = rd_idx_q;
  assign cam_write_enable_o  = wr_en_q;
  assign cam_write_index_o   = wr_idx_q;
  assign cam_write_data_o    = wr_data_q;
  assign cam_search_enable_o = srch_en_q;
  assign cam_search_data_o   = srch_data_q;

endmodule

// File: tb/tb_cam_cmd_scheduler.sv
// Directed plus randomized bench for cam_cmd_scheduler with a behavioural CAM
// stub and a queue-based expected-response model.
module tb_cam_cmd_scheduler;

  localparam int unsigned CMD_DEPTH = 4;
  localparam int unsigned RSP_DEPTH = 4;
  localparam int unsigned CAM_LAT   = 1;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i, cmd_ready_o;
  logic [1:0]  cmd_op_i;
  logic [4:0]  cmd_index_i;
  logic [31:0] cmd_data_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [1:0]  rsp_op_o;
  logic        rsp_hit_o;
  logic [4:0]  rsp_index_o;
  logic [31:0] rsp_data_o;
  logic        cam_read_enable_o, cam_write_enable_o, cam_search_enable_o;
  logic [4:0]  cam_read_index_o, cam_write_index_o;
  logic [31:0] cam_write_data_o, cam_search_data_o;
  logic        cam_read_valid_i, cam_search_valid_i;
  logic [31:0] cam_read_value_i;
  logic [4:0]  cam_search_index_i;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  cam_cmd_scheduler #(.CMD_DEPTH(CMD_DEPTH), .RSP_DEPTH(RSP_DEPTH), .CAM_LAT(CAM_LAT)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .cmd_valid_i         (cmd_valid_i),
    .cmd_ready_o         (cmd_ready_o),
    .cmd_op_i            (cmd_op_i),
    .cmd_index_i         (cmd_index_i),
    .cmd_data_i          (cmd_data_i),
    .rsp_valid_o         (rsp_valid_o),
    .rsp_ready_i         (rsp_ready_i),
    .rsp_op_o            (rsp_op_o),
    .rsp_hit_o           (rsp_hit_o),
    .rsp_index_o         (rsp_index_o),
    .rsp_data_o          (rsp_data_o),
    .cam_read_enable_o   (cam_read_enable_o),
    .cam_read_index_o    (cam_read_index_o),
    .cam_write_enable_o  (cam_write_enable_o),
    .cam_write_index_o   (cam_write_index_o),
    .cam_write_data_o    (cam_write_data_o),
    .cam_search_enable_o (cam_search_enable_o),
    .cam_search_data_o   (cam_search_data_o),
    .cam_read_valid_i    (cam_read_valid_i),
    .cam_read_value_i    (cam_read_value_i),
    .cam_search_valid_i  (cam_search_valid_i),
    .cam_search_index_i  (cam_search_index_i)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // CAM stub: one-cycle latency, lowest matching valid entry wins a search.
  logic [31:0] cam_mem [32];
  logic [31:0] cam_vld;
  always @(posedge clk_i) begin : cam_stub
    logic       found;
    logic [4:0] fidx;
    found = 1'b0;
    fidx  = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (cam_vld[i] && cam_mem[i] == cam_search_data_o) begin
        found = 1'b1;
        fidx  = 5'(i);
      end
    end
    cam_read_valid_i   <= cam_read_enable_o && cam_vld[cam_read_index_o];
    cam_read_value_i   <= cam_mem[cam_read_index_o];
    cam_search_valid_i <= cam_search_enable_o && found;
    cam_search_index_i <= fidx;
    if (cam_write_enable_o) begin
      cam_mem[cam_write_index_o] <= cam_write_data_o;
      cam_vld[cam_write_index_o] <= 1'b1;
    end
  end

  // Reference model: CAM contents as seen in command-accept order.
  logic [31:0] m_mem [32];
  logic [31:0] m_vld;
  logic [39:0] exp_q [$];
  int          acc_count = 0;

  task automatic model_accept(input logic [1:0] op, input logic [4:0] idx, input logic [31:0] data);
    logic [39:0] e;
    int          hit_at;
    acc_count++;
    case (op)
      2'd0: e = {2'd0, m_vld[idx], idx, m_mem[idx]};
      2'd1: begin
        m_mem[idx] = data;
        m_vld[idx] = 1'b1;
        e = {2'd1, 1'b1, idx, data};
      end
      2'd2: begin
        hit_at = -1;
        for (int i = 0; i < 32 && hit_at < 0; i++) begin
          if (m_vld[i] && m_mem[i] == data) hit_at = i;
        end
        e = (hit_at >= 0) ? {2'd2, 1'b1, 5'(hit_at), data} : {2'd2, 1'b0, 5'd0, data};
      end
      default: e = {2'd3, 1'b0, idx, data};
    endcase
    exp_q.push_back(e);
  endtask

  // Monitor: enable accounting and in-order response scoreboard.
  int          cyc = 0;
  int          en_count = 0, wen_count = 0;
  int          first_en_cyc = -1, last_en_cyc = -1;
  logic [4:0]  last_widx = '0;
  always @(posedge clk_i) cyc++;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      check("cam_en_onehot",
            64'($countones({cam_read_enable_o, cam_write_enable_o, cam_search_enable_o}) <= 1), 64'(1));
      if (cam_read_enable_o || cam_write_enable_o || cam_search_enable_o) begin
        en_count++;
        last_en_cyc = cyc;
        if (first_en_cyc < 0) first_en_cyc = cyc;
      end
      if (cam_write_enable_o) begin
        wen_count++;
        last_widx = cam_write_index_o;
      end
      if (rsp_valid_o && rsp_ready_i) begin
        if (exp_q.size() == 0) begin
          check("rsp_expected_pending", 64'(exp_q.size()), 64'(1));
        end else begin
          check("rsp_payload", 64'({rsp_op_o, rsp_hit_o, rsp_index_o, rsp_data_o}), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [4:0] idx, input logic [31:0] data);
    int waitc = 0;
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_index_i = idx;
    cmd_data_i  = data;
    while (!cmd_ready_o && waitc < 200) begin
      @(posedge clk_i); #1;
      waitc++;
    end
    if (!cmd_ready_o) begin
      check("cmd_accept_timeout", 64'(cmd_ready_o), 64'(1));
    end else begin
      @(posedge clk_i);
      model_accept(op, idx, data);
      #1;
    end
    cmd_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    rsp_ready_i = 1'b1;
    while ((exp_q.size() != 0 || rsp_valid_o) && n < 500) begin
      @(posedge clk_i); #1;
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  function automatic logic [31:0] rnd_data();
    case ($urandom_range(0, 3))
      0:       return 32'hA5A5_0001;
      1:       return 32'h1234_5678;
      2:       return 32'h0BAD_F00D;
      default: return $urandom;
    endcase
  endfunction

  bit rand_done = 1'b0;
  int en0, wen0, acc0, lat, n;

  initial begin
    cmd_valid_i = 1'b0;
    cmd_op_i    = '0;
    cmd_index_i = '0;
    cmd_data_i  = '0;
    rsp_ready_i = 1'b0;
    cam_vld     = '0;
    m_vld       = '0;
    for (int i = 0; i < 32; i++) begin
      cam_mem[i] = '0;
      m_mem[i]   = '0;
    end

    // Reset state.
    repeat (3) @(posedge clk_i);
    #1;
    check("ready_in_reset", 64'(cmd_ready_o), 64'(0));
    check("reset_enables", 64'({cam_read_enable_o, cam_write_enable_o, cam_search_enable_o}), 64'(0));
    check("reset_rsp_valid", 64'(rsp_valid_o), 64'(0));
    rst_i = 1'b0;
    #1;
    check("ready_after_reset", 64'(cmd_ready_o), 64'(1));

    // Write then read back.
    wen0 = wen_count;
    send(2'd1, 5'd3, 32'hDEAD_BEEF);
    send(2'd0, 5'd3, 32'h0);
    drain();
    check("t1_write_pulses", 64'(wen_count - wen0), 64'(1));
    check("t1_write_index", 64'(last_widx), 64'(3));

    // Search hit and miss.
    send(2'd1, 5'd7, 32'h1234_5678);
    send(2'd2, 5'd0, 32'h1234_5678);
    send(2'd2, 5'd0, 32'h0BAD_F00D);
    drain();

    // Minimum latency from an idle pipeline.
    send(2'd0, 5'd7, 32'h0);
    lat = 1;
    while (!rsp_valid_o && lat < 20) begin
      @(posedge clk_i); #1;
      lat++;
    end
    check("min_latency", 64'(lat), 64'(CAM_LAT + 3));
    drain();

    // Streamed reads: one enable per cycle with no bubbles.
    en0 = en_count;
    first_en_cyc = -1;
    for (int i = 0; i < 16; i++) send(2'd0, 5'(i), 32'h0);
    drain();
    check("stream_enables", 64'(en_count - en0), 64'(16));
    check("stream_span", 64'(last_en_cyc - first_en_cyc + 1), 64'(16));

    // Illegal opcode between reads.
    en0 = en_count;
    send(2'd0, 5'd3, 32'h0);
    send(2'd3, 5'd9, 32'hCAFE_0003);
    send(2'd0, 5'd7, 32'h0);
    drain();
    check("illegal_enables", 64'(en_count - en0), 64'(2));

    // Backpressure: credit caps issued ops, command FIFO then fills.
    rsp_ready_i = 1'b0;
    en0  = en_count;
    acc0 = acc_count;
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          send(2'($urandom_range(0, 2)), 5'($urandom_range(0, 7)), rnd_data());
        end
      end
    join_none
    repeat (20) @(posedge clk_i);
    #1;
    check("bp_issued", 64'(en_count - en0), 64'(RSP_DEPTH));
    check("bp_accepted", 64'(acc_count - acc0), 64'(RSP_DEPTH + CMD_DEPTH));
    check("bp_ready_low", 64'(cmd_ready_o), 64'(0));
    rsp_ready_i = 1'b1;
    n = 0;
    while (acc_count - acc0 < 10 && n < 200) begin
      @(posedge clk_i); #1;
      n++;
    end
    check("bp_all_accepted", 64'(acc_count - acc0), 64'(10));
    drain();

    // Randomized traffic with random response backpressure.
    rand_done = 1'b0;
    fork
      begin
        while (!rand_done) begin
          @(posedge clk_i); #1;
          rsp_ready_i = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int k = 0; k < 120; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk_i); #1;
      end
      send(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), rnd_data());
    end
    rand_done = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    drain();

    // Reset with commands queued and one in flight.
    rsp_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) send(2'd0, 5'(k), 32'h0);
    rst_i       = 1'b1;
    cmd_valid_i = 1'b1;
    cmd_op_i    = 2'd0;
    cmd_index_i = 5'd1;
    #1;
    check("ready_during_rst", 64'(cmd_ready_o), 64'(0));
    @(posedge clk_i); #1;
    rst_i       = 1'b0;
    cmd_valid_i = 1'b0;
    exp_q.delete();
    #1;
    check("rst_enables", 64'({cam_read_enable_o, cam_write_enable_o, cam_search_enable_o}), 64'(0));
    check("rst_cam_regs", 64'({cam_read_index_o, cam_write_index_o, cam_write_data_o[7:0]}), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
    check("rst_ready", 64'(cmd_ready_o), 64'(1));
    rsp_ready_i = 1'b1;
    repeat (10) @(posedge clk_i);
    #1;
    check("rst_no_stale_rsp", 64'(rsp_valid_o), 64'(0));
    send(2'd0, 5'd7, 32'h0);
    send(2'd2, 5'd0, 32'hDEAD_BEEF);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
